// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the program-counter sequencer.
//   run_state_t  run-control state (RUN, HALTED, STEP)
//   F3_*         funct3 encodings of the conditional branches
package pc_seq_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HALTED = 2'd1,
      STEP   = 2'd2
   } run_state_t;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decode/flag/debug inputs and PC-control outputs of the
// program-counter sequencer.
//   master : control side (drives decode, ALU flags, debug requests)
//   slave  : pc_sequencer (drives pc_src_o, pc_en_o, halted_o, counters)
// Parameter CNT_W: width of the performance counter signals.
interface pc_sequencer_if #(
   parameter int unsigned CNT_W = 32
) ();

   logic             branch_i;
   logic             jump_i;
   logic [2:0]       funct3_i;
   logic             eq_i;
   logic             lt_i;
   logic             ltu_i;
   logic             ebreak_i;
   logic             halt_req_i;
   logic             resume_i;
   logic             step_i;
   logic             pc_src_o;
   logic             pc_en_o;
   logic             halted_o;
   logic [CNT_W-1:0] cycle_cnt_o;
   logic [CNT_W-1:0] instret_o;

   modport master (
      output branch_i, jump_i, funct3_i, eq_i, lt_i, ltu_i,
             ebreak_i, halt_req_i, resume_i, step_i,
      input  pc_src_o, pc_en_o, halted_o, cycle_cnt_o, instret_o
   );

   modport slave (
      input  branch_i, jump_i, funct3_i, eq_i, lt_i, ltu_i,
             ebreak_i, halt_req_i, resume_i, step_i,
      output pc_src_o, pc_en_o, halted_o, cycle_cnt_o, instret_o
   );

endinterface

// File: rtl/pc_sequencer_branch_cond.sv
// branch_cond_unit: evaluates the conditional-branch predicate from funct3
// and the ALU comparison flags. Purely combinational.
//   funct3_i  branch condition code
//   eq_i      rs1 == rs2
//   lt_i      rs1 <  rs2 signed
//   ltu_i     rs1 <  rs2 unsigned
//   taken_o   condition holds (0 for the unused codes 010/011)
module branch_cond_unit
   import pc_seq_pkg::*;
(
   input  logic [2:0] funct3_i,
   input  logic       eq_i,
   input  logic       lt_i,
   input  logic       ltu_i,
   output logic       taken_o
);

   always_comb begin
      taken_o = 1'b0;
      case (funct3_i)
         F3_BEQ:  taken_o = eq_i;
         F3_BNE:  taken_o = !eq_i;
         F3_BLT:  taken_o = lt_i;
         F3_BGE:  taken_o = !lt_i;
         F3_BLTU: taken_o = ltu_i;
         F3_BGEU: taken_o = !ltu_i;
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC select and run/halt/single-step control for the
// program counter.
//   clk       core clock, all state on posedge
//   rst       synchronous, active-high reset
//   bus       pc_sequencer_if.slave: decode/flags/debug in; pc_src_o,
//             pc_en_o, halted_o, cycle_cnt_o, instret_o out
// Parameters: START_HALTED (reset state HALTED when 1, else RUN),
//             CNT_W (performance counter width).
// Optional feature: define PC_SEQ_PERF_EN to build the cycle and
// retired-instruction counters; otherwise those outputs are constant 0.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter bit          START_HALTED = 1'b0,
   parameter int unsigned CNT_W        = 32
) (
   input logic           clk,
   input logic           rst,
   pc_sequencer_if.slave bus
);

   localparam run_state_t RESET_STATE = START_HALTED ? HALTED : RUN;

   run_state_t state_q, state_d;
   logic       halted_q;
   logic       pc_en;
   logic       taken;

   branch_cond_unit u_cond (
      .funct3_i (bus.funct3_i),
      .eq_i     (bus.eq_i),
      .lt_i     (bus.lt_i),
      .ltu_i    (bus.ltu_i),
      .taken_o  (taken)
   );

   assign bus.pc_src_o = bus.jump_i | (bus.branch_i & taken);

   // pc_en depends on the current-cycle inputs so that a halt request or
   // EBREAK freezes the PC in the very cycle it is seen.
   always_comb begin
      state_d = state_q;
      pc_en   = 1'b0;
      case (state_q)
         RUN: begin
            pc_en = !bus.ebreak_i & !bus.halt_req_i;
            if (bus.ebreak_i | bus.halt_req_i) state_d = HALTED;
         end
         HALTED: begin
            if (bus.resume_i)    state_d = RUN;
            else if (bus.step_i) state_d = STEP;
         end
         STEP: begin
            pc_en   = !bus.ebreak_i;
            state_d = HALTED;
         end
         default: state_d = RESET_STATE;
      endcase
   end

   // halted_q mirrors the decode of the next state so halted_o is a flop
   // that equals (state_q == HALTED).
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RESET_STATE;
         halted_q <= START_HALTED;
      end else begin
         state_q  <= state_d;
         halted_q <= (state_d == HALTED);
      end
   end

   assign bus.pc_en_o  = pc_en;
   assign bus.halted_o = halted_q;

`ifdef PC_SEQ_PERF_EN
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   always_comb begin
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      instret_d   = instret_q + CNT_W'(pc_en);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt_q <= '0;
         instret_q   <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         instret_q   <= instret_d;
      end
   end

   assign bus.cycle_cnt_o = cycle_cnt_q;
   assign bus.instret_o   = instret_q;
`else
   assign bus.cycle_cnt_o = {CNT_W{1'b0}};
   assign bus.instret_o   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
   import pc_seq_pkg::*;

`ifdef PC_SEQ_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   // Expected counter values (4-bit, wrap naturally)
   logic [3:0] exp_cyc = '0;
   logic [3:0] exp_ret = '0;
   logic [3:0] want_cyc, want_ret;

   always #5 clk = ~clk;

   pc_sequencer_if #(.CNT_W(4)) bus   ();
   pc_sequencer_if #(.CNT_W(4)) bus_h ();

   pc_sequencer #(.START_HALTED(1'b0), .CNT_W(4)) dut (
      .clk (clk), .rst (rst), .bus (bus)
   );

   pc_sequencer #(.START_HALTED(1'b1), .CNT_W(4)) dut_h (
      .clk (clk), .rst (rst), .bus (bus_h)
   );

   // One clock cycle; en is the pc_en value the bench expects during it.
   task automatic cyc(input bit en);
      @(posedge clk);
      if (rst) begin
         exp_cyc = '0;
         exp_ret = '0;
      end else begin
         exp_cyc = exp_cyc + 4'd1;
         if (en) exp_ret = exp_ret + 4'd1;
      end
      #1;
      want_cyc = PERF ? exp_cyc : 4'd0;
      want_ret = PERF ? exp_ret : 4'd0;
   endtask

   task automatic idle_inputs();
      bus.branch_i = 0; bus.jump_i = 0; bus.funct3_i = 3'b000;
      bus.eq_i = 0; bus.lt_i = 0; bus.ltu_i = 0; bus.ebreak_i = 0;
      bus.halt_req_i = 0; bus.resume_i = 0; bus.step_i = 0;
      bus_h.branch_i = 0; bus_h.jump_i = 0; bus_h.funct3_i = 3'b000;
      bus_h.eq_i = 0; bus_h.lt_i = 0; bus_h.ltu_i = 0; bus_h.ebreak_i = 0;
      bus_h.halt_req_i = 0; bus_h.resume_i = 0; bus_h.step_i = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      cyc(0); cyc(0);
      checks++; if (bus.halted_o !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", bus.halted_o); end
      checks++; if (bus.pc_en_o !== 1'b1) begin errors++; $display("FAIL reset_pc_en got=%b exp=1", bus.pc_en_o); end
      checks++; if (bus.cycle_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_cycle got=%0d exp=0", bus.cycle_cnt_o); end
      checks++; if (bus.instret_o !== 4'd0) begin errors++; $display("FAIL reset_instret got=%0d exp=0", bus.instret_o); end
      checks++; if (bus_h.halted_o !== 1'b1) begin errors++; $display("FAIL reset_sh_halted got=%b exp=1", bus_h.halted_o); end
      checks++; if (bus_h.pc_en_o !== 1'b0) begin errors++; $display("FAIL reset_sh_pc_en got=%b exp=0", bus_h.pc_en_o); end
      rst = 0;
      cyc(1);
      checks++; if (bus.cycle_cnt_o !== want_cyc) begin errors++; $display("FAIL run_cycle1 got=%0d exp=%0d", bus.cycle_cnt_o, want_cyc); end
      cyc(1);
      checks++; if (bus.instret_o !== want_ret) begin errors++; $display("FAIL run_instret2 got=%0d exp=%0d", bus.instret_o, want_ret); end
      checks++; if (bus_h.halted_o !== 1'b1) begin errors++; $display("FAIL sh_stays_halted got=%b exp=1", bus_h.halted_o); end
   endtask

   task automatic test_branch();
      // {funct3, eq, lt, ltu, expected taken}
      logic [6:0] vec [0:11];
      vec[0]  = {3'b000, 3'b100, 1'b1};  vec[1]  = {3'b000, 3'b011, 1'b0};
      vec[2]  = {3'b001, 3'b100, 1'b0};  vec[3]  = {3'b001, 3'b000, 1'b1};
      vec[4]  = {3'b100, 3'b010, 1'b1};  vec[5]  = {3'b100, 3'b101, 1'b0};
      vec[6]  = {3'b101, 3'b010, 1'b0};  vec[7]  = {3'b101, 3'b000, 1'b1};
      vec[8]  = {3'b110, 3'b001, 1'b1};  vec[9]  = {3'b111, 3'b001, 1'b0};
      vec[10] = {3'b010, 3'b111, 1'b0};  vec[11] = {3'b011, 3'b111, 1'b0};
      bus.branch_i = 1; bus.funct3_i = 3'b101; bus.lt_i = 1; #1;
      checks++; if (bus.pc_src_o !== 1'b0) begin errors++; $display("FAIL bge_lt got=%b exp=0", bus.pc_src_o); end
      bus.lt_i = 0; #1;
      checks++; if (bus.pc_src_o !== 1'b1) begin errors++; $display("FAIL bge_ge got=%b exp=1", bus.pc_src_o); end
      bus.lt_i = 1; bus.jump_i = 1; #1;
      checks++; if (bus.pc_src_o !== 1'b1) begin errors++; $display("FAIL jump_wins got=%b exp=1", bus.pc_src_o); end
      bus.jump_i = 0;
      for (int i = 0; i < 12; i++) begin
         bus.funct3_i = vec[i][6:4];
         bus.eq_i = vec[i][3]; bus.lt_i = vec[i][2]; bus.ltu_i = vec[i][1];
         #1;
         checks++;
         if (bus.pc_src_o !== vec[i][0]) begin
            errors++; $display("FAIL cond_vec%0d got=%b exp=%b", i, bus.pc_src_o, vec[i][0]);
         end
      end
      bus.branch_i = 0; bus.funct3_i = 3'b001; bus.eq_i = 0; #1;
      checks++; if (bus.pc_src_o !== 1'b0) begin errors++; $display("FAIL no_branch got=%b exp=0", bus.pc_src_o); end
      bus.jump_i = 1; #1;
      checks++; if (bus.pc_src_o !== 1'b1) begin errors++; $display("FAIL jump_only got=%b exp=1", bus.pc_src_o); end
      idle_inputs();
   endtask

   task automatic test_ebreak();
      bus.ebreak_i = 1; #1;
      checks++; if (bus.pc_en_o !== 1'b0) begin errors++; $display("FAIL ebreak_pc_en got=%b exp=0", bus.pc_en_o); end
      checks++; if (bus.halted_o !== 1'b0) begin errors++; $display("FAIL ebreak_not_yet got=%b exp=0", bus.halted_o); end
      cyc(0);
      bus.ebreak_i = 0; #1;
      checks++; if (bus.halted_o !== 1'b1) begin errors++; $display("FAIL ebreak_halted got=%b exp=1", bus.halted_o); end
      checks++; if (bus.pc_en_o !== 1'b0) begin errors++; $display("FAIL halted_pc_en got=%b exp=0", bus.pc_en_o); end
      checks++; if (bus.instret_o !== want_ret) begin errors++; $display("FAIL ebreak_instret got=%0d exp=%0d", bus.instret_o, want_ret); end
   endtask

   task automatic test_step();
      bus.step_i = 1; #1;
      checks++; if (bus.pc_en_o !== 1'b0) begin errors++; $display("FAIL step_req_pc_en got=%b exp=0", bus.pc_en_o); end
      cyc(0);
      bus.step_i = 0; #1;
      checks++; if (bus.halted_o !== 1'b0) begin errors++; $display("FAIL step_state got=%b exp=0", bus.halted_o); end
      checks++; if (bus.pc_en_o !== 1'b1) begin errors++; $display("FAIL step_pc_en got=%b exp=1", bus.pc_en_o); end
      cyc(1);
      checks++; if (bus.halted_o !== 1'b1) begin errors++; $display("FAIL step_rehalt got=%b exp=1", bus.halted_o); end
      checks++; if (bus.pc_en_o !== 1'b0) begin errors++; $display("FAIL step_after_pc_en got=%b exp=0", bus.pc_en_o); end
      checks++; if (bus.instret_o !== want_ret) begin errors++; $display("FAIL step_instret got=%0d exp=%0d", bus.instret_o, want_ret); end
      // Step onto an EBREAK: nothing executes, back to HALTED
      bus.step_i = 1; cyc(0); bus.step_i = 0; bus.ebreak_i = 1; #1;
      checks++; if (bus.pc_en_o !== 1'b0) begin errors++; $display("FAIL step_ebreak_pc_en got=%b exp=0", bus.pc_en_o); end
      cyc(0); bus.ebreak_i = 0; #1;
      checks++; if (bus.halted_o !== 1'b1) begin errors++; $display("FAIL step_ebreak_halt got=%b exp=1", bus.halted_o); end
   endtask

   task automatic test_resume_priority();
      bus.resume_i = 1; bus.step_i = 1; cyc(0);
      bus.resume_i = 0; bus.step_i = 0; #1;
      checks++; if (bus.halted_o !== 1'b0) begin errors++; $display("FAIL resume_prio_state got=%b exp=0", bus.halted_o); end
      checks++; if (bus.pc_en_o !== 1'b1) begin errors++; $display("FAIL resume_prio_pc_en got=%b exp=1", bus.pc_en_o); end
      cyc(1);
      checks++; if (bus.halted_o !== 1'b0) begin errors++; $display("FAIL resume_is_run got=%b exp=0", bus.halted_o); end
      bus.halt_req_i = 1; #1;
      checks++; if (bus.pc_en_o !== 1'b0) begin errors++; $display("FAIL halt_req_same_cycle got=%b exp=0", bus.pc_en_o); end
      cyc(0); cyc(0);
      checks++; if (bus.halted_o !== 1'b1) begin errors++; $display("FAIL halt_req_held got=%b exp=1", bus.halted_o); end
      checks++; if (bus.pc_en_o !== 1'b0) begin errors++; $display("FAIL halt_req_held_pc_en got=%b exp=0", bus.pc_en_o); end
      // resume with halt_req still held: enters RUN, stops again at once
      bus.resume_i = 1; cyc(0); bus.resume_i = 0; #1;
      checks++; if (bus.halted_o !== 1'b0) begin errors++; $display("FAIL resume_under_halt got=%b exp=0", bus.halted_o); end
      checks++; if (bus.pc_en_o !== 1'b0) begin errors++; $display("FAIL resume_under_halt_pc_en got=%b exp=0", bus.pc_en_o); end
      cyc(0); bus.halt_req_i = 0; #1;
      checks++; if (bus.halted_o !== 1'b1) begin errors++; $display("FAIL rehalt_req got=%b exp=1", bus.halted_o); end
      // resume onto a held EBREAK re-halts
      bus.ebreak_i = 1; bus.resume_i = 1; cyc(0); bus.resume_i = 0; #1;
      checks++; if (bus.pc_en_o !== 1'b0) begin errors++; $display("FAIL resume_ebreak_pc_en got=%b exp=0", bus.pc_en_o); end
      cyc(0); bus.ebreak_i = 0; #1;
      checks++; if (bus.halted_o !== 1'b1) begin errors++; $display("FAIL resume_ebreak_halt got=%b exp=1", bus.halted_o); end
      checks++; if (bus.instret_o !== want_ret) begin errors++; $display("FAIL resume_instret got=%0d exp=%0d", bus.instret_o, want_ret); end
   endtask

   task automatic test_wrap();
      rst = 1; cyc(0); rst = 0; #1;
      for (int i = 0; i < 17; i++) cyc(1);
      checks++; if (bus.cycle_cnt_o !== want_cyc) begin errors++; $display("FAIL wrap_cycle got=%0d exp=%0d", bus.cycle_cnt_o, want_cyc); end
      checks++; if (bus.instret_o !== want_ret) begin errors++; $display("FAIL wrap_instret got=%0d exp=%0d", bus.instret_o, want_ret); end
   endtask

   task automatic test_reset_mid_step();
      bus.halt_req_i = 1; cyc(0); bus.halt_req_i = 0;
      bus.step_i = 1; cyc(0); bus.step_i = 0; #1;
      checks++; if (bus.pc_en_o !== 1'b1) begin errors++; $display("FAIL mid_step_pc_en got=%b exp=1", bus.pc_en_o); end
      rst = 1; bus.step_i = 1; bus.resume_i = 1; cyc(0);
      rst = 0; bus.step_i = 0; bus.resume_i = 0; #1;
      checks++; if (bus.halted_o !== 1'b0) begin errors++; $display("FAIL rst_step_state got=%b exp=0", bus.halted_o); end
      checks++; if (bus.pc_en_o !== 1'b1) begin errors++; $display("FAIL rst_step_pc_en got=%b exp=1", bus.pc_en_o); end
      checks++; if (bus.cycle_cnt_o !== 4'd0) begin errors++; $display("FAIL rst_step_cycle got=%0d exp=0", bus.cycle_cnt_o); end
      checks++; if (bus.instret_o !== 4'd0) begin errors++; $display("FAIL rst_step_instret got=%0d exp=0", bus.instret_o); end
      checks++; if (bus_h.halted_o !== 1'b1) begin errors++; $display("FAIL rst_sh_halted got=%b exp=1", bus_h.halted_o); end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_branch();
      test_ebreak();
      test_step();
      test_resume_priority();
      test_wrap();
      test_reset_mid_step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
